// File: rtl/legv8_main_control_fsm_pkg.sv
// Shared constants for the LEGv8 multi-cycle main control unit:
// opcode patterns, ALUOp encodings, state encodings and decode class bundle.
package legv8_main_control_fsm_pkg;

    localparam logic [10:0] OP_ADD   = 11'b10001011000;
    localparam logic [10:0] OP_SUB   = 11'b11001011000;
    localparam logic [10:0] OP_AND   = 11'b10001010000;
    localparam logic [10:0] OP_ORR   = 11'b10101010000;
    localparam logic [10:0] OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] OP_STUR  = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ8  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ8 = 8'b10110101;
    localparam logic [5:0]  OP_B6    = 6'b000101;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_CB  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_WB_R   = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM_RD = 4'd6,
        S_WB_LD  = 4'd7,
        S_MEM_WR = 4'd8,
        S_CB     = 4'd9,
        S_BR     = 4'd10,
        S_TRAP   = 4'd11
    } state_t;

    typedef struct packed {
        logic r;
        logic ld;
        logic st;
        logic cb;
        logic b;
        logic cbnz;
        logic illegal;
    } op_class_t;

endpackage

// File: rtl/legv8_main_control_fsm_opcode_decode.sv
// Combinational opcode classifier for the main control unit.
// CBNZ decodes as its own class only when CTRL_CBNZ_EN is defined.
module legv8_opcode_decode
    import legv8_main_control_fsm_pkg::*;
(
    input  logic [10:0] opcode,
    output op_class_t   cls
);

    logic w_r;
    logic w_ld;
    logic w_st;
    logic w_cb;
    logic w_b;
    logic w_cbnz;

    assign w_r  = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                  (opcode == OP_AND) || (opcode == OP_ORR);
    assign w_ld = (opcode == OP_LDUR);
    assign w_st = (opcode == OP_STUR);
    assign w_cb = (opcode[10:3] == OP_CBZ8);
    assign w_b  = (opcode[10:5] == OP_B6);

`ifdef CTRL_CBNZ_EN
    assign w_cbnz = (opcode[10:3] == OP_CBNZ8);
`else
    assign w_cbnz = 1'b0;
`endif

    always_comb begin
        cls         = '0;
        cls.r       = w_r;
        cls.ld      = w_ld;
        cls.st      = w_st;
        cls.cb      = w_cb;
        cls.b       = w_b;
        cls.cbnz    = w_cbnz;
        cls.illegal = ~(w_r | w_ld | w_st | w_cb | w_b | w_cbnz);
    end

endmodule

// File: rtl/legv8_main_control_fsm.sv
// LEGv8 multi-cycle main control FSM with mem_ready wait states.
// Optional CBNZ support is enabled by defining CTRL_CBNZ_EN.
module legv8_main_control_fsm
    import legv8_main_control_fsm_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [10:0]        opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               ALUOp0,
    output logic               ALUOp1,
    output logic               Reg2Loc,
    output logic               ALUSrc,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               pc_write,
    output logic               pc_src,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_dbg
);

    state_t     r_state;
    state_t     w_next;
    op_class_t  w_cls;
    logic [1:0] w_aluop;
    logic       w_taken;

    legv8_opcode_decode u_dec (
        .opcode (opcode),
        .cls    (w_cls)
    );

    assign w_taken = (w_cls.cb & zero) | (w_cls.cbnz & ~zero);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_aluop    = ALUOP_ADD;
        Reg2Loc    = 1'b0;
        ALUSrc     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        illegal_op = 1'b0;
        unique case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                MemRead = 1'b1;
                if (mem_ready) begin
                    IRWrite  = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_DECODE;
                end
            end
            S_DECODE: begin
                Reg2Loc = w_cls.st | w_cls.cb | w_cls.cbnz;
                unique case (1'b1)
                    w_cls.r:                w_next = S_EXEC_R;
                    w_cls.ld, w_cls.st:     w_next = S_ADDR;
                    w_cls.cb, w_cls.cbnz:   w_next = S_CB;
                    w_cls.b:                w_next = S_BR;
                    default:                w_next = S_TRAP;
                endcase
            end
            S_EXEC_R: begin
                w_aluop = ALUOP_R;
                w_next  = S_WB_R;
            end
            S_WB_R: begin
                w_aluop  = ALUOP_R;
                RegWrite = 1'b1;
                w_next   = S_FETCH;
            end
            S_ADDR: begin
                ALUSrc = 1'b1;
                w_next = w_cls.ld ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                ALUSrc  = 1'b1;
                MemRead = 1'b1;
                if (mem_ready) w_next = S_WB_LD;
            end
            S_WB_LD: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                w_next   = S_FETCH;
            end
            S_MEM_WR: begin
                ALUSrc   = 1'b1;
                Reg2Loc  = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) w_next = S_FETCH;
            end
            S_CB: begin
                w_aluop  = ALUOP_CB;
                Reg2Loc  = 1'b1;
                pc_write = w_taken;
                pc_src   = w_taken;
                w_next   = S_FETCH;
            end
            S_BR: begin
                pc_write = 1'b1;
                pc_src   = 1'b1;
                w_next   = S_FETCH;
            end
            S_TRAP: illegal_op = 1'b1;
            default: w_next = S_IDLE;
        endcase
    end

    assign ALUOp1    = w_aluop[1];
    assign ALUOp0    = w_aluop[0];
    assign state_dbg = STATE_W'(r_state);

endmodule
